keypad_scanner: RTL

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_pkg.sv | 35 +++
 rtl/keypad_debounce.sv | 60 ++++++
 rtl/keypad_scanner.sv | 93 +++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared constants, key map and frame state encoding for the 4x3 keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS   = 4;
  localparam int NUM_COLS   = 3;
  localparam int NUM_DIGITS = 10;
  localparam int ROW_W      = $clog2(NUM_ROWS);

  typedef logic [3:0] digit_t;
  localparam digit_t NO_KEY = 4'hF;

  // Rows top to bottom, columns left to right; '*' and '#' carry no digit.
  localparam digit_t KEY_MAP [NUM_ROWS][NUM_COLS] = '{
    '{4'd1,   4'd2, 4'd3  },
    '{4'd4,   4'd5, 4'd6  },
    '{4'd7,   4'd8, 4'd9  },
    '{NO_KEY, 4'd0, NO_KEY}
  };

  typedef enum logic {
    SCAN = 1'b0,
    EVAL = 1'b1
  } frame_state_e;

  function automatic logic [NUM_DIGITS-1:0] row_digits(input logic [ROW_W-1:0]    row,
                                                       input logic [NUM_COLS-1:0] pressed);
    logic [NUM_DIGITS-1:0] bits;
    bits = '0;
    for (int c = 0; c < NUM_COLS; c++) begin
      if (pressed[c] && (KEY_MAP[row][c] != NO_KEY)) bits[KEY_MAP[row][c]] = 1'b1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debouncer: commits a frame code after DEBOUNCE_FRAMES identical frames.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  eval,
  input  logic [NUM_DIGITS-1:0] frame_code,
  output logic [NUM_DIGITS-1:0] keypad,
  output logic                  key_pulse
);

  localparam int             MW        = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [MW-1:0]  MATCH_MAX = MW'(DEBOUNCE_FRAMES);

  logic [NUM_DIGITS-1:0] candidate;
  logic [NUM_DIGITS-1:0] cand_next;
  logic [MW-1:0]         match_cnt;
  logic [MW-1:0]         match_next;
  logic                  commit;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cand_next  = candidate;
    match_next = match_cnt;
    commit     = 1'b0;
    if (eval) begin
      if (frame_code == candidate) begin
        if (match_cnt != MATCH_MAX) begin
          match_next = match_cnt + MW'(1);
          commit     = (match_next == MATCH_MAX);
        end
      end else begin
        cand_next  = frame_code;
        match_next = MW'(1);
        commit     = (MATCH_MAX == MW'(1));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      candidate <= '0;
      match_cnt <= '0;
      keypad    <= '0;
      key_pulse <= 1'b0;
    end else begin
      candidate <= cand_next;
      match_cnt <= match_next;
      key_pulse <= 1'b0;
      if (commit) begin
        keypad    <= cand_next;
        key_pulse <= (cand_next != '0) && (cand_next != keypad);
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x3 matrix keypad scanner with debounced one-hot digit output.
// Define KEYPAD_GHOST_REJECT_EN to blank multi-key frames instead of keeping the lowest digit.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_CYCLES     = 4,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic [NUM_COLS-1:0]   col_n,
  output logic [NUM_ROWS-1:0]   row_n,
  output logic [NUM_DIGITS-1:0] keypad,
  output logic                  key_pulse
);

  localparam int            DW         = $clog2(SCAN_CYCLES);
  localparam logic [DW-1:0] LAST_DWELL = DW'(SCAN_CYCLES - 1);

  logic [NUM_COLS-1:0]   col_meta;
  logic [NUM_COLS-1:0]   col_sync;
  logic [ROW_W-1:0]      row_idx;
  logic [DW-1:0]         dwell;
  frame_state_e          state;
  logic [NUM_DIGITS-1:0] frame_acc;
  logic [NUM_DIGITS-1:0] frame_code;
  logic [NUM_DIGITS-1:0] frame_raw;
  logic                  sample;

  function automatic logic [NUM_DIGITS-1:0] resolve_frame(input logic [NUM_DIGITS-1:0] raw);
`ifdef KEYPAD_GHOST_REJECT_EN
    return ($countones(raw) > 1) ? '0 : raw;
`else
    return raw & (~raw + NUM_DIGITS'(1));
`endif
  endfunction

  // Columns are read only at the end of a dwell, giving the synchronizer time to settle.
  assign sample    = (dwell == LAST_DWELL);
  assign frame_raw = frame_acc | row_digits(row_idx, ~col_sync);

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      col_meta   <= '0;
      col_sync   <= '0;
      state      <= SCAN;
      row_idx    <= '0;
      row_n      <= 4'b1110;
      dwell      <= '0;
      frame_acc  <= '0;
      frame_code <= '0;
    end else begin
      col_meta <= col_n;
      col_sync <= col_meta;
      unique case (state)
        SCAN: begin
          if (sample) begin
            dwell   <= '0;
            row_idx <= row_idx + ROW_W'(1);
            row_n   <= {row_n[NUM_ROWS-2:0], row_n[NUM_ROWS-1]};
            if (row_idx == ROW_W'(NUM_ROWS - 1)) begin
              frame_code <= resolve_frame(frame_raw);
              frame_acc  <= '0;
              state      <= EVAL;
            end else begin
              frame_acc <= frame_raw;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end
        // Row 0 is already driven here; this cycle is the first of its dwell.
        EVAL: begin
          dwell <= dwell + DW'(1);
          state <= SCAN;
        end
      endcase
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clock     (clock),
    .resetn    (resetn),
    .eval      (state == EVAL),
    .frame_code(frame_code),
    .keypad    (keypad),
    .key_pulse (key_pulse)
  );

endmodule
